// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes and FSM states shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration (div=0: add-shift multiply, div=1: restoring subtract-shift divide) on {upper, lower} accumulator
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);
  logic [WIDTH:0] sum, rsh, trial;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rsh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial = rsh - {1'b0, opnd};
    acc_next = div ? (trial[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                   : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU + MTHI/MTLO with HI/LO regs; in clk,reset,start,op,src_a,src_b,cancel; out busy,done,hi,lo
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0] opnd, a_mag, b_mag, quo, rem;
  logic is_div, pneg, rneg, dz, sgn, idle_req, go;
  assign idle_req = state == IDLE && start && !cancel;
  assign go = idle_req && op <= OP_DIVU;
  assign sgn = !op[0];
  assign a_mag = sgn && src_a[WIDTH-1] ? -src_a : src_a;
  assign b_mag = sgn && src_b[WIDTH-1] ? -src_b : src_b;
  assign prod = pneg ? -acc : acc;
  assign quo = pneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div      (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );
  always_comb begin
    state_next = state;
    if (state == IDLE && go) state_next = RUN;
    if (state == RUN && cnt == CW'(WIDTH - 1)) state_next = FIX;
    if (state == FIX) state_next = IDLE;
    if (cancel) state_next = IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= state_next != IDLE;
      done <= state == FIX && !cancel;
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (state == RUN) acc <= acc_next;
      if (go) begin
        acc <= {{WIDTH{1'b0}}, a_mag};
        opnd <= b_mag;
        is_div <= op[1];
        pneg <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        rneg <= sgn && src_a[WIDTH-1];
        dz <= op[1] && src_b == '0;
      end
      if (idle_req && op == OP_MTHI) hi <= src_a;
      if (idle_req && op == OP_MTLO) lo <= src_a;
      if (state == FIX && !cancel) begin
        hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];
      end
    end
  end
endmodule
